// File: rtl/alex_filter_sequencer.sv
// Alex filter relay sequencer: detects LPF/HPF/TX changes, mutes TX, waits for the PA
// to drain, shifts the 16-bit relay word out MSB-first, latches it and waits for the relays to settle.
module alex_filter_sequencer #(
   parameter int CLK_DIV       = 2,
   parameter int SETTLE_CYCLES = 4800
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] lpf,
   input  logic [5:0] hpf,
   input  logic       tx,
   input  logic       force_update,
   input  logic       pa_idle,
   output logic       spi_clk,
   output logic       spi_data,
   output logic       spi_load,
   output logic       tx_inhibit,
   output logic       busy
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, WAIT_IDLE, SHIFT, LATCH, SETTLE} state_t;

   state_t        state;
   logic [13:0]   fields;
   logic [13:0]   committed;
   logic          pending;
   logic          changed;
   logic          pend_now;
   logic [15:0]   word;
   logic [14:0]   shreg;
   logic [DW-1:0] div_cnt;
   logic [3:0]    bit_cnt;
   logic [SW-1:0] settle_cnt;

   assign fields   = {tx, lpf, hpf};
   assign word     = {1'b0, fields[13:6], 1'b0, fields[5:0]};
   assign changed  = (fields != committed) || force_update;
   // Using the live change term lets IDLE react on the same edge and lets SETTLE
   // hand over to IDLE without a one-cycle dip in tx_inhibit.
   assign pend_now = pending || changed;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         committed  <= '0;
         pending    <= 1'b1;
         spi_clk    <= 1'b0;
         spi_data   <= 1'b0;
         spi_load   <= 1'b0;
         tx_inhibit <= 1'b1;
         busy       <= 1'b0;
         shreg      <= '0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         settle_cnt <= '0;
      end else begin
         if (changed) pending <= 1'b1;
         case (state)
            IDLE: begin
               if (pend_now) begin
                  state      <= WAIT_IDLE;
                  tx_inhibit <= 1'b1;
                  busy       <= 1'b1;
               end else begin
                  tx_inhibit <= 1'b0;
               end
            end
            WAIT_IDLE: begin
               // Snapshot takes the newest inputs, so anything pending is covered here.
               if (pa_idle) begin
                  shreg     <= word[14:0];
                  committed <= fields;
                  pending   <= 1'b0;
                  spi_data  <= word[15];
                  spi_clk   <= 1'b0;
                  div_cnt   <= '0;
                  bit_cnt   <= '0;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (!spi_clk) begin
                     spi_clk <= 1'b1;
                  end else begin
                     spi_clk <= 1'b0;
                     if (bit_cnt == 4'd15) begin
                        spi_load <= 1'b1;
                        state    <= LATCH;
                     end else begin
                        bit_cnt  <= bit_cnt + 4'd1;
                        spi_data <= shreg[14];
                        shreg    <= {shreg[13:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            LATCH: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt    <= '0;
                  spi_load   <= 1'b0;
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  tx_inhibit <= pend_now;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alex_filter_sequencer.sv
// Directed bench for alex_filter_sequencer; a negedge monitor reassembles the serial
// words and counts latch pulses, spi_clk rises and tx_inhibit falls.
module tb_alex_filter_sequencer;

   localparam int CLK_DIV       = 2;
   localparam int SETTLE_CYCLES = 10;
   // Edges from the IDLE->WAIT decision to tx_inhibit falling: 1 + 1 + 32*2 + 2 + 10
   localparam int LATENCY = 1 + 1 + 32 * CLK_DIV + CLK_DIV + SETTLE_CYCLES;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] lpf;
   logic [5:0] hpf;
   logic       tx;
   logic       forceUpdate;
   logic       paIdle;
   logic       spiClk;
   logic       spiData;
   logic       spiLoad;
   logic       txInhibit;
   logic       busy;

   int checkCount = 0;
   int errorCount = 0;

   logic        prevClk = 1'b0;
   logic        prevLoad = 1'b0;
   logic        prevInhibit = 1'b1;
   logic        prevData = 1'b0;
   logic [15:0] rxWord = '0;
   logic [15:0] lastWord = '0;
   logic [15:0] prevWord = '0;
   int          rxBits = 0;
   int          lastBits = 0;
   int          riseCount = 0;
   int          latchCount = 0;
   int          loadCycles = 0;
   int          inhibitFalls = 0;
   int          clashCount = 0;
   int          glitchCount = 0;

   alex_filter_sequencer #(
      .CLK_DIV(CLK_DIV),
      .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .clock(clock),
      .reset(reset),
      .lpf(lpf),
      .hpf(hpf),
      .tx(tx),
      .force_update(forceUpdate),
      .pa_idle(paIdle),
      .spi_clk(spiClk),
      .spi_data(spiData),
      .spi_load(spiLoad),
      .tx_inhibit(txInhibit),
      .busy(busy)
   );

   always #5 clock = ~clock;

   // Reassemble shifted bits on spi_clk rises and record each latched word.
   always @(negedge clock) begin
      if (reset) begin
         rxBits = 0;
         rxWord = '0;
      end else begin
         if (spiClk && !prevClk) begin
            rxWord = {rxWord[14:0], spiData};
            rxBits++;
            riseCount++;
         end
         if (spiClk && prevClk && (spiData != prevData)) glitchCount++;
         if (spiLoad && !prevLoad) begin
            prevWord = lastWord;
            lastWord = rxWord;
            lastBits = rxBits;
            rxBits   = 0;
            latchCount++;
         end
         if (spiLoad) loadCycles++;
         if (spiLoad && spiClk) clashCount++;
         if (!txInhibit && prevInhibit) inhibitFalls++;
      end
      prevClk     = spiClk;
      prevLoad    = spiLoad;
      prevInhibit = txInhibit;
      prevData    = spiData;
   end

   // Every comparison funnels through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] l, input logic [5:0] h, input logic t);
      @(negedge clock);
      lpf = l;
      hpf = h;
      tx  = t;
   endtask

   task automatic pulseForce();
      @(negedge clock);
      forceUpdate = 1'b1;
      @(negedge clock);
      forceUpdate = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget);
      int cycles;
      cycles = 0;
      do begin
         @(negedge clock);
         cycles++;
      end while ((busy || txInhibit) && cycles < budget);
      #1;
      checkOutput(tag, 32'(cycles < budget), 32'd1);
   endtask

   task automatic waitRises(input string tag, input int n, input int budget);
      int base;
      int cycles;
      base   = riseCount;
      cycles = 0;
      do begin
         @(negedge clock);
         #1;
         cycles++;
      end while ((riseCount - base) < n && cycles < budget);
      checkOutput(tag, 32'(cycles < budget), 32'd1);
   endtask

   initial begin
      int cycles;
      int lowCount;
      int baseLatch;
      int baseLoad;
      int baseRise;
      int baseFalls;

      lpf = 7'b0001000;
      hpf = 6'b000000;
      tx = 1'b0;
      forceUpdate = 1'b0;
      paIdle = 1'b1;
      reset = 1'b1;

      // Test 1: reset state and the mandatory first transfer
      repeat (3) @(negedge clock);
      checkOutput("rstSpiClk", 32'(spiClk), 32'd0);
      checkOutput("rstSpiData", 32'(spiData), 32'd0);
      checkOutput("rstSpiLoad", 32'(spiLoad), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstInhibit", 32'(txInhibit), 32'd1);
      baseLatch = latchCount;
      baseLoad  = loadCycles;
      reset = 1'b0;
      @(negedge clock);
      cycles = 1;
      checkOutput("t1BusyFirst", 32'(busy), 32'd1);
      checkOutput("t1InhibitFirst", 32'(txInhibit), 32'd1);
      while (txInhibit && cycles < 500) begin
         @(negedge clock);
         cycles++;
      end
      #1;
      checkOutput("t1Latency", 32'(cycles), 32'(LATENCY));
      checkOutput("t1Latches", 32'(latchCount - baseLatch), 32'd1);
      checkOutput("t1Word", 32'(lastWord), 32'h0400);
      checkOutput("t1Bits", 32'(lastBits), 32'd16);
      checkOutput("t1LoadCycles", 32'(loadCycles - baseLoad), 32'd2);
      checkOutput("t1BusyEnd", 32'(busy), 32'd0);

      // Test 2: steady inputs, nothing moves
      baseRise = riseCount;
      lowCount = 0;
      repeat (200) begin
         @(negedge clock);
         if (!txInhibit) lowCount++;
      end
      #1;
      checkOutput("t2Rises", 32'(riseCount - baseRise), 32'd0);
      checkOutput("t2InhibitLow", 32'(lowCount), 32'd200);
      checkOutput("t2Busy", 32'(busy), 32'd0);

      // Test 3: change held off by pa_idle=0
      baseLatch = latchCount;
      applyStimulus(7'b0000001, 6'b000000, 1'b0);
      waitDone("t3aDone", 500);
      checkOutput("t3aWord", 32'(lastWord), 32'h0080);
      @(negedge clock);
      paIdle = 1'b0;
      lpf = 7'b1000000;
      baseRise = riseCount;
      baseLatch = latchCount;
      @(negedge clock);
      checkOutput("t3InhibitNext", 32'(txInhibit), 32'd1);
      checkOutput("t3BusyNext", 32'(busy), 32'd1);
      repeat (19) @(negedge clock);
      #1;
      checkOutput("t3NoRises", 32'(riseCount - baseRise), 32'd0);
      checkOutput("t3InhibitHeld", 32'(txInhibit), 32'd1);
      paIdle = 1'b1;
      waitDone("t3Done", 500);
      checkOutput("t3Latches", 32'(latchCount - baseLatch), 32'd1);
      checkOutput("t3Word", 32'(lastWord), 32'h2000);

      // Test 4: tx toggled mid-shift gives two back-to-back transfers
      baseLatch = latchCount;
      baseFalls = inhibitFalls;
      applyStimulus(7'b1000000, 6'b000101, 1'b0);
      waitRises("t4Rises", 8, 300);
      tx = 1'b1;
      waitDone("t4Done", 1000);
      checkOutput("t4Latches", 32'(latchCount - baseLatch), 32'd2);
      checkOutput("t4FirstWord", 32'(prevWord), 32'h2005);
      checkOutput("t4SecondWord", 32'(lastWord), 32'h6005);
      checkOutput("t4InhibitFalls", 32'(inhibitFalls - baseFalls), 32'd1);

      // Test 5: force_update alone, then coinciding with an hpf change
      baseLatch = latchCount;
      pulseForce();
      waitDone("t5aDone", 500);
      checkOutput("t5aLatches", 32'(latchCount - baseLatch), 32'd1);
      checkOutput("t5aWord", 32'(lastWord), 32'h6005);
      baseLatch = latchCount;
      @(negedge clock);
      hpf = 6'b100000;
      forceUpdate = 1'b1;
      @(negedge clock);
      forceUpdate = 1'b0;
      waitDone("t5bDone", 500);
      repeat (20) @(negedge clock);
      #1;
      checkOutput("t5bLatches", 32'(latchCount - baseLatch), 32'd1);
      checkOutput("t5bWord", 32'(lastWord), 32'h6020);

      // Test 6: reset in the middle of a shift aborts without a latch
      baseLatch = latchCount;
      applyStimulus(7'b0000010, 6'b100000, 1'b1);
      waitRises("t6Rises", 5, 300);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("t6SpiClk", 32'(spiClk), 32'd0);
      checkOutput("t6SpiLoad", 32'(spiLoad), 32'd0);
      checkOutput("t6Inhibit", 32'(txInhibit), 32'd1);
      checkOutput("t6Busy", 32'(busy), 32'd0);
      #1;
      checkOutput("t6NoLatch", 32'(latchCount - baseLatch), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      waitDone("t6Done", 500);
      checkOutput("t6Latches", 32'(latchCount - baseLatch), 32'd1);
      checkOutput("t6Word", 32'(lastWord), 32'h4120);
      checkOutput("t6Bits", 32'(lastBits), 32'd16);

      checkOutput("loadClash", 32'(clashCount), 32'd0);
      checkOutput("dataGlitch", 32'(glitchCount), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
